// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects, load-use/branch/mul-div stalls and an HI/LO busy FSM.
// Define HAZARD_PERF_EN to build the stallcount/flushcount performance counters.
module hazard_unit #(
    parameter int unsigned MD_LATENCY = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [4:0]  rsE,
    input  logic [4:0]  rtE,
    input  logic [4:0]  writeregE,
    input  logic [4:0]  writeregM,
    input  logic [4:0]  writeregW,
    input  logic        regwriteE,
    input  logic        regwriteM,
    input  logic        regwriteW,
    input  logic        memtoregE,
    input  logic        memtoregM,
    input  logic        branchD,
    input  logic        mdstartE,
    input  logic        mdreadD,
    output logic        stallF,
    output logic        stallD,
    output logic        flushE,
    output logic        forwardAD,
    output logic        forwardBD,
    output logic [1:0]  forwardAE,
    output logic [1:0]  forwardBE,
    output logic        mdbusy,
    output logic [31:0] stallcount,
    output logic [31:0] flushcount
);

    localparam int unsigned CntW = $clog2(MD_LATENCY + 1);

    typedef enum logic {StIdle, StBusy} md_state_e;

    md_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic lwstall, branchstall, mdstall, stall;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] wr_m,
                                           input logic rw_m, input logic [4:0] wr_w,
                                           input logic rw_w);
        if (src != 5'd0 && src == wr_m && rw_m) begin
            return 2'b10;
        end else if (src != 5'd0 && src == wr_w && rw_w) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        lwstall     = memtoregE && (rtE == rsD || rtE == rtD);
        branchstall = branchD &&
                      ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                       (memtoregM && (writeregM == rsD || writeregM == rtD)));
        // A read issued alongside the start must also wait for the result.
        mdstall     = mdreadD && (mdbusy || mdstartE);
        stall       = lwstall || branchstall || mdstall;
    end

    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        flushE    = 1'b0;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (!reset) begin
            stallF    = stall;
            stallD    = stall;
            flushE    = stall;
            forwardAD = (rsD != 5'd0) && (rsD == writeregM) && regwriteM;
            forwardBD = (rtD != 5'd0) && (rtD == writeregM) && regwriteM;
            forwardAE = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
            forwardBE = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
        end
    end

    assign mdbusy = (state_q == StBusy);

    // A start while busy is ignored: no reload, no extension.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (mdstartE) begin
                    state_d = StBusy;
                    cnt_d   = CntW'(MD_LATENCY - 1);
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stallcount_q, flushcount_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stallcount_q <= 32'd0;
            flushcount_q <= 32'd0;
        end else begin
            if (stallD) begin
                stallcount_q <= stallcount_q + 32'd1;
            end
            if (flushE && branchstall) begin
                flushcount_q <= flushcount_q + 32'd1;
            end
        end
    end

    assign stallcount = stallcount_q;
    assign flushcount = flushcount_q;
`else
    assign stallcount = 32'd0;
    assign flushcount = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table, directed mul/div/reset/perf sequences,
// and randomized traffic against a cycle-count reference model.
module tb_hazard_unit;

    localparam int unsigned Lat = 4;

`ifdef HAZARD_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic        regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic        branchD, mdstartE, mdreadD;
    logic        stallF, stallD, flushE, forwardAD, forwardBD, mdbusy;
    logic [1:0]  forwardAE, forwardBE;
    logic [31:0] stallcount, flushcount;

    int nvec = 0;
    int nerr = 0;

    // Reference model: remaining busy cycles plus the two event counts.
    int          m_rem = 0;
    logic [31:0] m_sc  = 32'd0;
    logic [31:0] m_fc  = 32'd0;

    always #5 clk = ~clk;

    hazard_unit #(.MD_LATENCY(Lat)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .mdstartE(mdstartE), .mdreadD(mdreadD),
        .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .mdbusy(mdbusy), .stallcount(stallcount), .flushcount(flushcount)
    );

    typedef struct {
        logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic       rw_e, rw_m, rw_w, mt_e, mt_m, br_d;
        logic [1:0] e_ae, e_be;
        logic       e_ad, e_bd, e_st;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr();
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
        {branchD, mdstartE, mdreadD} = '0;
        reset = 1'b0;
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (src == 0) return 2'd0;
        if (src == writeregM && regwriteM) return 2'd2;
        if (src == writeregW && regwriteW) return 2'd1;
        return 2'd0;
    endfunction

    // Inputs are already driven (after a negedge); check, clock, advance model.
    task automatic tick(input string tag);
        logic lw, br, md, st;
        #1;
        lw = memtoregE && (rtE == rsD || rtE == rtD);
        br = branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                         (memtoregM && (writeregM == rsD || writeregM == rtD)));
        md = mdreadD && (m_rem > 0 || mdstartE);
        st = !reset && (lw || br || md);
        chk({tag, ".stallF"}, 32'(stallF), 32'(st));
        chk({tag, ".stallD"}, 32'(stallD), 32'(st));
        chk({tag, ".flushE"}, 32'(flushE), 32'(st));
        chk({tag, ".fwdAE"}, 32'(forwardAE), reset ? 32'd0 : 32'(m_fwd(rsE)));
        chk({tag, ".fwdBE"}, 32'(forwardBE), reset ? 32'd0 : 32'(m_fwd(rtE)));
        chk({tag, ".fwdAD"}, 32'(forwardAD),
            32'(!reset && rsD != 0 && rsD == writeregM && regwriteM));
        chk({tag, ".fwdBD"}, 32'(forwardBD),
            32'(!reset && rtD != 0 && rtD == writeregM && regwriteM));
        chk({tag, ".mdbusy"}, 32'(mdbusy), 32'(m_rem > 0));
        chk({tag, ".stallcount"}, stallcount, PerfEn ? m_sc : 32'd0);
        chk({tag, ".flushcount"}, flushcount, PerfEn ? m_fc : 32'd0);
        @(posedge clk);
        if (reset) begin
            m_rem = 0;
            m_sc  = 32'd0;
            m_fc  = 32'd0;
        end else begin
            if (st) m_sc = m_sc + 32'd1;
            if (st && br) m_fc = m_fc + 32'd1;
            if (m_rem > 0) m_rem = m_rem - 1;
            else if (mdstartE) m_rem = Lat;
        end
        @(negedge clk);
    endtask

    initial begin
        // rsD rtD rsE rtE wE wM wW | rwE rwM rwW mtE mtM brD | eAE eBE eAD eBD eSt
        tbl[0]  = '{0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 0, 0, 0, 2, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 5, 0, 0, 5, 5, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 5, 5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{7, 0, 7, 7, 0, 7, 7, 0, 1, 1, 0, 0, 0, 2, 2, 1, 0, 0};
        tbl[4]  = '{8, 0, 0, 8, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[5]  = '{9, 9, 0, 8, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{3, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        tbl[7]  = '{3, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1};
        tbl[8]  = '{3, 0, 0, 0, 3, 3, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 1};
        tbl[9]  = '{0, 4, 0, 0, 0, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[10] = '{0, 0, 0, 6, 0, 6, 6, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};

        clr();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Outputs forced low under reset even with hazardous inputs.
        memtoregE = 1'b1; rtE = 5'd8; rsD = 5'd8; rsE = 5'd5; writeregM = 5'd5;
        regwriteM = 1'b1; mdreadD = 1'b1; mdstartE = 1'b1;
        tick("rst");
        clr();

        for (int i = 0; i < 11; i++) begin
            rsD = tbl[i].rs_d; rtD = tbl[i].rt_d; rsE = tbl[i].rs_e; rtE = tbl[i].rt_e;
            writeregE = tbl[i].wr_e; writeregM = tbl[i].wr_m; writeregW = tbl[i].wr_w;
            regwriteE = tbl[i].rw_e; regwriteM = tbl[i].rw_m; regwriteW = tbl[i].rw_w;
            memtoregE = tbl[i].mt_e; memtoregM = tbl[i].mt_m; branchD = tbl[i].br_d;
            #1;
            chk($sformatf("tbl%0d.ae", i), 32'(forwardAE), 32'(tbl[i].e_ae));
            chk($sformatf("tbl%0d.be", i), 32'(forwardBE), 32'(tbl[i].e_be));
            chk($sformatf("tbl%0d.ad", i), 32'(forwardAD), 32'(tbl[i].e_ad));
            chk($sformatf("tbl%0d.bd", i), 32'(forwardBD), 32'(tbl[i].e_bd));
            chk($sformatf("tbl%0d.st", i), 32'({stallF, stallD, flushE}), {29'd0, {3{tbl[i].e_st}}});
            tick($sformatf("tbl%0d", i));
        end
        clr();

        // Mul/div latency: busy cycles 1..Lat, read stalls cycles 0..Lat.
        for (int c = 0; c <= 5; c++) begin
            mdstartE = (c == 0);
            mdreadD  = 1'b1;
            #1;
            chk($sformatf("md.c%0d.busy", c), 32'(mdbusy), 32'(c >= 1 && c <= 4));
            chk($sformatf("md.c%0d.stall", c), 32'(stallD), 32'(c <= 4));
            tick($sformatf("md.c%0d", c));
        end
        clr();

        // Reset aborts an in-flight operation.
        for (int c = 0; c <= 3; c++) begin
            mdstartE = (c == 0);
            reset    = (c == 2);
            mdreadD  = (c >= 2);
            #1;
            if (c == 3) begin
                chk("abort.busy", 32'(mdbusy), 32'd0);
                chk("abort.stall", 32'(stallD), 32'd0);
            end
            tick($sformatf("abort.c%0d", c));
        end
        clr();

        // Performance counters: 3 load-use + 2 branch stalls after reset.
        reset = 1'b1;
        tick("perf.rst");
        clr();
        for (int c = 0; c < 5; c++) begin
            clr();
            if (c < 3) begin
                memtoregE = 1'b1; rtE = 5'd8; rsD = 5'd8;
            end else begin
                branchD = 1'b1; regwriteE = 1'b1; writeregE = 5'd3; rsD = 5'd3;
            end
            tick($sformatf("perf.c%0d", c));
        end
        clr();
        #1;
        chk("perf.stallcount", stallcount, PerfEn ? 32'd5 : 32'd0);
        chk("perf.flushcount", flushcount, PerfEn ? 32'd2 : 32'd0);
        tick("perf.end");

        // Randomized traffic, small register range to force collisions.
        for (int n = 0; n < 2000; n++) begin
            rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
            writeregE = 5'($urandom_range(0, 3)); writeregM = 5'($urandom_range(0, 3));
            writeregW = 5'($urandom_range(0, 3));
            regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
            memtoregE = ($urandom_range(0, 3) == 0); memtoregM = ($urandom_range(0, 3) == 0);
            branchD   = ($urandom_range(0, 2) == 0);
            mdstartE  = ($urandom_range(0, 7) == 0);
            mdreadD   = 1'($urandom);
            reset     = ($urandom_range(0, 63) == 0);
            tick($sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
